gate_recv: RTL

Receive-side route gate, the counterpart of the send-side route-capability table. The host writes 8-bit route capabilities into a per-source table; each inbound AXI4-Stream packet carries a route tag in its first beat, and the block compares that tag against the table entry for the tagged source. A packet whose tag matches is forwarded whole; any other packet is consumed and discarded. The block sits between the network-facing stream and the user-logic stream.

---
 rtl/gate_recv.sv | 115 +++++++++++
 1 files changed

// File: rtl/gate_recv.sv
// Receive-side route gate: admits inbound packets whose first-beat tag matches the
// per-source capability table. Drop counter is built only with GATE_RECV_DROP_CNT_EN.
module gate_recv #(
    parameter int N_SRCS    = 4,
    parameter int DATA_BITS = 512
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [7:0]           host_route_cap_in,
    input  logic                 host_route_cap_valid,
    input  logic                 host_route_clr,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [1:0]           ul_port_out,
    output logic [15:0]          drop_cnt
);

    typedef enum logic [1:0] {IDLE, CHECK, PASS, DROP} state_t;

    state_t            state;
    logic [7:0]        tag_q;
    logic [7:0]        cap_data [N_SRCS];
    logic [N_SRCS-1:0] cap_vld;
    logic              match;
    logic              in_pass;
    logic              in_drop;

    // NOTE: valid bits are reset, entry bytes are not; contents behind a clear
    // valid bit are never looked at, so the data array needs no reset path.
    always_ff @(posedge aclk) begin
        if (host_route_cap_valid) begin
            for (int i = 0; i < N_SRCS; i++) begin
                if (host_route_cap_in[1:0] == 2'(i))
                    cap_data[i] <= host_route_cap_in;
            end
        end
    end

    // Clear takes priority over a write landing in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cap_vld <= '0;
        end else if (host_route_clr) begin
            cap_vld <= '0;
        end else if (host_route_cap_valid) begin
            for (int i = 0; i < N_SRCS; i++) begin
                if (host_route_cap_in[1:0] == 2'(i))
                    cap_vld[i] <= 1'b1;
            end
        end
    end

    // NOTE: match gets a default before the loop so no latch is inferred.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < N_SRCS; i++) begin
            if (tag_q[1:0] == 2'(i) && cap_vld[i] && cap_data[i] == tag_q)
                match = 1'b1;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, including the table read during CHECK.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            tag_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        tag_q <= s_axis_tdata[7:0];
                        state <= CHECK;
                    end
                end
                CHECK:   state <= match ? PASS : DROP;
                PASS:    if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state <= IDLE;
                DROP:    if (s_axis_tvalid && s_axis_tlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_pass = (state == PASS);
    assign in_drop = (state == DROP);

    // PASS is a zero-latency wire path; other states present idle outputs.
    assign m_axis_tvalid = in_pass & s_axis_tvalid;
    assign m_axis_tlast  = in_pass & s_axis_tlast;
    assign m_axis_tdata  = in_pass ? s_axis_tdata : '0;
    assign s_axis_tready = in_pass ? m_axis_tready : in_drop;
    assign ul_port_out   = in_pass ? tag_q[1:0] : 2'b00;

`ifdef GATE_RECV_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            drop_q <= '0;
        else if (in_drop && s_axis_tvalid && s_axis_tlast && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule
